// File: rtl/ga_pkg.sv
// ga_pkg
// Shared types and constants for the genetic-algorithm fitness evaluator.
//   SIZE       coordinate width in bits
//   MAX_COORD  largest legal coordinate value
//   coord_t    one coordinate
//   fit_t      fitness value; one bit wider than a coordinate so that
//              |dx| + |dy| can never overflow
//   FIT_WORST  all-ones fitness given to out-of-range candidates
//   state_t    generation FSM states
package ga_pkg;

    localparam int SIZE      = 8;
    localparam int MAX_COORD = 180;

    typedef logic [SIZE-1:0] coord_t;
    typedef logic [SIZE:0]   fit_t;

    localparam fit_t FIT_WORST = '1;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        DONE
    } state_t;

    // True when either coordinate lies outside the legal playing field.
    function automatic logic out_of_range(input coord_t x, input coord_t y);
        return (x > coord_t'(MAX_COORD)) || (y > coord_t'(MAX_COORD));
    endfunction

endpackage

// File: rtl/ga_fitness_eval_if.sv
// ga_fitness_eval_if
// Bundles the candidate handshake, the per-candidate fitness stream and
// the end-of-generation result of the fitness evaluator.
//   master modport: the chromosome generator / selection side
//   slave  modport: the fitness evaluator itself
// Signals:
//   target_x/target_y  target coordinate
//   cand_valid/ready   candidate handshake, cand_x/cand_y the candidate
//   fit_valid/fit      per-candidate fitness (lower is better)
//   gen_done           one-cycle pulse at end of a generation
//   best_x/best_y/best_fit  best candidate of last completed generation
//   gen_count          completed generations (wraps)
interface ga_fitness_eval_if;
    import ga_pkg::*;

    coord_t      target_x;
    coord_t      target_y;
    logic        cand_valid;
    logic        cand_ready;
    coord_t      cand_x;
    coord_t      cand_y;
    logic        fit_valid;
    fit_t        fit;
    logic        gen_done;
    coord_t      best_x;
    coord_t      best_y;
    fit_t        best_fit;
    logic [15:0] gen_count;

    modport master (
        output target_x, target_y, cand_valid, cand_x, cand_y,
        input  cand_ready, fit_valid, fit, gen_done,
               best_x, best_y, best_fit, gen_count
    );

    modport slave (
        input  target_x, target_y, cand_valid, cand_x, cand_y,
        output cand_ready, fit_valid, fit, gen_done,
               best_x, best_y, best_fit, gen_count
    );

endinterface

// File: rtl/ga_abs_diff.sv
// ga_abs_diff
// Combinational unsigned absolute difference of two coordinates.
//   a, b  : coordinates
//   diff  : |a - b|, same width as the inputs
module ga_abs_diff
    import ga_pkg::*;
(
    input  coord_t a,
    input  coord_t b,
    output coord_t diff
);

    // Subtract the smaller from the larger so the result never wraps.
    assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/ga_fitness_eval.sv
// ga_fitness_eval
// Scores candidate (x, y) coordinates against a target coordinate with the
// Manhattan distance and tracks the best candidate of each generation of
// POP_SIZE candidates.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    ga_fitness_eval_if.slave (candidate handshake, fitness stream,
//          end-of-generation best result, generation counter)
// Parameters:
//   POP_SIZE  candidates per generation (2 or more)
// Build option:
//   GA_FIT_RANGE_CHECK_EN  when defined, a candidate with either coordinate
//                          above MAX_COORD is scored FIT_WORST.
// Pipeline: candidate capture -> S1 absolute differences -> S2 sum, so a
// candidate accepted at edge N shows fit_valid after edge N+2.
module ga_fitness_eval
    import ga_pkg::*;
#(
    parameter int POP_SIZE = 16
)
(
    input  logic clk,
    input  logic reset,
    ga_fitness_eval_if.slave bus
);

    localparam int CNT_W = $clog2(POP_SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(POP_SIZE - 1);

    // Generation FSM and its registered outputs
    state_t           state;
    logic [CNT_W-1:0] count;
    logic             cand_ready_q;
    logic             gen_done_q;
    coord_t           best_x_q;
    coord_t           best_y_q;
    fit_t             best_fit_q;
    logic [15:0]      gen_count_q;

    // Handshake decode
    logic accept;
    logic first_accept;
    logic last_accept;

    // Target latched at the start of each generation
    coord_t tx;
    coord_t ty;

    // Capture stage
    logic   s0_valid;
    logic   s0_first;
    logic   s0_last;
    coord_t s0_x;
    coord_t s0_y;

    // S1: absolute differences
    coord_t dx;
    coord_t dy;
    logic   s1_valid;
    logic   s1_first;
    logic   s1_last;
    coord_t s1_x;
    coord_t s1_y;
    coord_t s1_dx;
    coord_t s1_dy;
`ifdef GA_FIT_RANGE_CHECK_EN
    logic   s1_oor;
`endif
    fit_t   s1_fit;

    // S2: fitness output
    logic   s2_valid;
    logic   s2_last;
    fit_t   s2_fit;

    // Running best of the generation in progress
    coord_t run_x;
    coord_t run_y;
    fit_t   run_fit;

    assign accept       = bus.cand_valid && cand_ready_q;
    // count is already zero while in DONE, so the same test covers a
    // first accept made directly out of DONE.
    assign first_accept = accept && (count == '0);
    assign last_accept  = accept && (count == LAST_IDX);

    ga_abs_diff u_diff_x (
        .a    (s0_x),
        .b    (tx),
        .diff (dx)
    );

    ga_abs_diff u_diff_y (
        .a    (s0_y),
        .b    (ty),
        .diff (dy)
    );

    // Sum of the registered differences; out-of-range candidates are forced
    // to the worst score so they lose against any legal candidate.
    always_comb begin
        s1_fit = fit_t'(s1_dx) + fit_t'(s1_dy);
`ifdef GA_FIT_RANGE_CHECK_EN
        if (s1_oor) begin
            s1_fit = FIT_WORST;
        end
`endif
    end

    // Datapath: capture, difference and sum stages, plus the running best.
    // Each candidate carries first/last-of-generation tags down the pipe so
    // the best tracker and the FSM know where the generation boundaries are
    // without counting results separately.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx       <= '0;
            ty       <= '0;
            s0_valid <= 1'b0;
            s0_first <= 1'b0;
            s0_last  <= 1'b0;
            s0_x     <= '0;
            s0_y     <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_dx    <= '0;
            s1_dy    <= '0;
`ifdef GA_FIT_RANGE_CHECK_EN
            s1_oor   <= 1'b0;
`endif
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_fit   <= '0;
            run_x    <= '0;
            run_y    <= '0;
            run_fit  <= '0;
        end else begin
            if (first_accept) begin
                tx <= bus.target_x;
                ty <= bus.target_y;
            end

            s0_valid <= accept;
            s0_first <= first_accept;
            s0_last  <= last_accept;
            if (accept) begin
                s0_x <= bus.cand_x;
                s0_y <= bus.cand_y;
            end

            s1_valid <= s0_valid;
            s1_first <= s0_valid && s0_first;
            s1_last  <= s0_valid && s0_last;
            if (s0_valid) begin
                s1_x  <= s0_x;
                s1_y  <= s0_y;
                s1_dx <= dx;
                s1_dy <= dy;
`ifdef GA_FIT_RANGE_CHECK_EN
                s1_oor <= out_of_range(s0_x, s0_y);
`endif
            end

            s2_valid <= s1_valid;
            s2_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                s2_fit <= s1_fit;
            end

            // Strict less-than keeps the earliest candidate on a tie.
            if (s1_valid && (s1_first || (s1_fit < run_fit))) begin
                run_x   <= s1_x;
                run_y   <= s1_y;
                run_fit <= s1_fit;
            end else if (state == DONE) begin
                run_x   <= '0;
                run_y   <= '0;
                run_fit <= '0;
            end
        end
    end

    // Generation FSM. DONE still offers cand_ready so the next generation
    // can start the cycle after the gen_done pulse; the candidate count is
    // cleared on entry to DONE so a first accept there looks like any other.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ACCEPT;
            count        <= '0;
            cand_ready_q <= 1'b0;
            gen_done_q   <= 1'b0;
            best_x_q     <= '0;
            best_y_q     <= '0;
            best_fit_q   <= '0;
            gen_count_q  <= '0;
        end else begin
            gen_done_q <= 1'b0;
            case (state)
                ACCEPT, DONE: begin
                    state        <= ACCEPT;
                    cand_ready_q <= 1'b1;
                    if (accept) begin
                        count <= count + 1'b1;
                        if (last_accept) begin
                            state        <= DRAIN;
                            cand_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    cand_ready_q <= 1'b0;
                    if (s2_valid && s2_last) begin
                        state        <= DONE;
                        cand_ready_q <= 1'b1;
                        gen_done_q   <= 1'b1;
                        best_x_q     <= run_x;
                        best_y_q     <= run_y;
                        best_fit_q   <= run_fit;
                        gen_count_q  <= gen_count_q + 16'd1;
                        count        <= '0;
                    end
                end
                default: begin
                    state        <= ACCEPT;
                    cand_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cand_ready = cand_ready_q;
    assign bus.fit_valid  = s2_valid;
    assign bus.fit        = s2_fit;
    assign bus.gen_done   = gen_done_q;
    assign bus.best_x     = best_x_q;
    assign bus.best_y     = best_y_q;
    assign bus.best_fit   = best_fit_q;
    assign bus.gen_count  = gen_count_q;

endmodule

// File: doc/ga_fitness_eval.md
# ga_fitness_eval

Scores candidate (x, y) coordinates produced by the population/breeding stage against a target coordinate. Tracks the best candidate over one generation of `POP_SIZE` candidates. Sits directly downstream of the chromosome generator inside `Genetic_Algorithm`. It feeds the per-candidate fitness and end-of-generation best result back to the selection logic.

## Interface
- `SIZE`, 8, coordinate width in bits
- `POP_SIZE`, 16, candidates per generation; must be 2 or more
- `MAX_COORD`, 180, largest legal coordinate value
- `CLK`  in  1  system clock; all logic on the rising edge
- `RESET`  in  1  one clock; reset is synchronous and active-low
- `TARGET_X`, `TARGET_Y`  in  SIZE  target coordinate
- `CAND_VALID`  in  1  candidate present
- `CAND_READY`  out  1  block accepts candidate
- `CAND_X`, `CAND_Y`  in  SIZE  candidate coordinate
- `FIT_VALID`  out  1  `FIT` valid this cycle
- `FIT`  out  SIZE+1  fitness; lower is better
- `GEN_DONE`  out  1  one-cycle pulse at end of generation
- `BEST_X`, `BEST_Y`  out  SIZE  best candidate of last completed generation
- `BEST_FIT`  out  SIZE+1  fitness of `BEST_X`/`BEST_Y`
- `GEN_COUNT`  out  16  completed generations, wraps at 65535→0

## Operation
- A candidate is accepted on any cycle with `CAND_VALID && CAND_READY`.
- Target latch:
  - `TARGET_X`/`TARGET_Y` are latched on the first accepted candidate of each generation.
  - Changing the target mid-generation has no effect until the next generation.
- Fitness formula: `FIT = |CAND_X − TX| + |CAND_Y − TY|`.
  - Each absolute difference is unsigned, SIZE bits.
  - The sum is SIZE+1 bits, so it cannot overflow.
- Pipeline:
  - S1 registers both absolute differences.
  - S2 registers the sum into `FIT` and raises `FIT_VALID`.
- Running best (internal):
  - Updated in S2 when the result is the first of the generation, or when `FIT < best`.
  - On a tie, the earlier candidate is kept.
- FSM states:
  - ACCEPT:
    - `CAND_READY=1`; counts accepted candidates.
    - Goes to DRAIN in the cycle after the `POP_SIZE`-th accept.
  - DRAIN:
    - `CAND_READY=0`.
    - Waits until the last candidate's S2 result has been compared, then goes to DONE.
  - DONE:
    - One cycle; `GEN_DONE=1`.
    - `BEST_*` are loaded from the running best in this same cycle, so they are visible together with `GEN_DONE`.
    - `GEN_COUNT` increments.
    - Running best and candidate count clear; next state is ACCEPT.
- `BEST_*` hold their value between `GEN_DONE` pulses.

## Timing
- Latency: a candidate accepted at edge N gives `FIT_VALID`/`FIT` after edge N+2.
- Throughput is 1 candidate/cycle in ACCEPT.
- `GEN_DONE`:
  - The last accept is at edge N.
  - The FSM is in DRAIN for edges N+1 and N+2.
  - `GEN_DONE` is high during the cycle after edge N+3.
  - The first accept of the next generation is possible at edge N+4.
- `CAND_VALID` low in ACCEPT stalls counting with no penalty.
  - Bubbles propagate as `FIT_VALID=0`.
- No backpressure on `FIT`: the consumer must take it on the cycle `FIT_VALID=1`.
- Reset:
  - While `RESET=0` at an edge, all outputs are 0, including `CAND_READY=0`.
  - The FSM goes to ACCEPT; pipeline valids, counters and running best are cleared.
  - `CAND_READY=1` in the first cycle after `RESET` returns high.
  - Reset mid-generation discards the partial generation; no `GEN_DONE` is produced for it.

## Configuration
- `GA_FIT_RANGE_CHECK_EN` defined:
  - A candidate with `CAND_X > MAX_COORD` or `CAND_Y > MAX_COORD` gets `FIT` = all ones (2^(SIZE+1)−1).
  - It can only become best if every candidate in the generation is out of range.
- `GA_FIT_RANGE_CHECK_EN` undefined:
  - No range check; out-of-range candidates are scored by the normal formula.
- Latency is identical either way; the flag is carried through S1.

## Structure
- Shared package `ga_pkg`:
  - `SIZE` and `MAX_COORD` constants.
  - `fit_t` typedef (`logic [SIZE:0]`).
  - `coord_t` typedef.
  - FSM state enum `{ACCEPT, DRAIN, DONE}`.
  - `FIT_WORST` constant.
- One sub-module, `ga_abs_diff`:
  - Combinational unsigned |a−b| on SIZE bits.
  - Instantiated twice, feeding the S1 registers.

## Test plan
- Reset held 3 cycles, released:
  - All outputs are 0 during reset.
  - `CAND_READY=1` in the first cycle after release.
- Target (90,90), candidate (100,80) accepted at edge N → `FIT=20`, `FIT_VALID=1` after edge N+2 only.
- Target (180,180), candidate (0,0) → `FIT=360`, with no overflow in 9 bits.
- `POP_SIZE=4`, target (50,50), candidates (60,50),(40,50),(55,55),(70,70):
  - FITs are 10, 10, 10, 40.
  - `GEN_DONE` pulses once with `BEST=(60,50)`, `BEST_FIT=10` (tie keeps earliest).
  - `GEN_COUNT=1`.
- Candidate (200,10), target (90,90):
  - With `GA_FIT_RANGE_CHECK_EN` → `FIT=511`.
  - Without → `FIT=190`.
- `RESET` asserted after 2 of 4 candidates:
  - No `GEN_DONE`; `GEN_COUNT` stays 0.
  - A following full generation completes normally.
